// File: rtl/rtsnoc_pkg.sv
// Shared RTSNoC definitions: local port codes, header/bus width helpers and
// the transmit arbiter state encoding.
package rtsnoc_pkg;

    localparam logic [2:0] NN = 3'd0;
    localparam logic [2:0] NE = 3'd1;
    localparam logic [2:0] EE = 3'd2;
    localparam logic [2:0] SE = 3'd3;
    localparam logic [2:0] SS = 3'd4;
    localparam logic [2:0] SW = 3'd5;
    localparam logic [2:0] WW = 3'd6;
    localparam logic [2:0] NW = 3'd7;

    function automatic int dst_width(input int size_x, input int size_y);
        return 3 + size_y + size_x;
    endfunction

    // Origin plus destination: two coordinate pairs and two local codes.
    function automatic int header_width(input int size_x, input int size_y);
        return 2 * size_x + 2 * size_y + 6;
    endfunction

    function automatic int bus_width(input int data_w, input int size_x, input int size_y);
        return data_w + header_width(size_x, size_y);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } tx_state_t;

endpackage

// File: rtl/rtsnoc_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// wrapping modulo N. Returns a one-hot winner and its binary index.
module rtsnoc_rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] win_idx,
    output logic          found
);

    localparam logic [PW:0] N_EXT = (PW + 1)'(N);

    // Both operands are below N, so a single conditional subtract wraps.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= N_EXT) begin
            s = s - N_EXT;
        end
        return s[PW-1:0];
    endfunction

    logic [N-1:0]  rot;
    logic [PW-1:0] offset;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot[gi] = eligible[wrap_add(ptr, PW'(gi))];
        end
    endgenerate

    always_comb begin
        offset = '0;
        found  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset = PW'(k);
                found  = 1'b1;
            end
        end
    end

    assign win_idx = wrap_add(ptr, offset);

    always_comb begin
        winner = '0;
        if (found) begin
            winner[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rtsnoc_tx_arbiter.sv
// Round-robin transmit arbiter sharing one RTSNoC router local port among
// several masters; stamps origin fields and holds the grant across bursts.
module rtsnoc_tx_arbiter
    import rtsnoc_pkg::*;
#(
    parameter int N_CLIENTS      = 4,
    parameter int NOC_LOCAL_ADR  = 0,
    parameter int NOC_X          = 0,
    parameter int NOC_Y          = 0,
    parameter int SOC_SIZE_X     = 1,
    parameter int SOC_SIZE_Y     = 1,
    parameter int NOC_DATA_WIDTH = 16,
    localparam int DST_W         = dst_width(SOC_SIZE_X, SOC_SIZE_Y),
    localparam int REQ_W         = DST_W + NOC_DATA_WIDTH,
    localparam int NOC_BUS_SIZE  = bus_width(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_CLIENTS-1:0]         req_i,
    input  logic [N_CLIENTS-1:0]         last_i,
    input  logic [N_CLIENTS*REQ_W-1:0]   flit_i,
    output logic [N_CLIENTS-1:0]         ack_o,
    output logic [N_CLIENTS-1:0]         grant_o,
    output logic [NOC_BUS_SIZE-1:0]      noc_din_o,
    output logic                         noc_wr_o,
    input  logic                         noc_wait_i
);

    localparam int PW     = $clog2(N_CLIENTS);
    localparam int ORIG_W = SOC_SIZE_X + SOC_SIZE_Y + 3;
    localparam logic [ORIG_W-1:0] ORIGIN = {SOC_SIZE_X'(NOC_X), SOC_SIZE_Y'(NOC_Y), 3'(NOC_LOCAL_ADR)};

    tx_state_t                 state_reg, state_next;
    logic [PW-1:0]             ptr_reg, ptr_next;
    logic [PW-1:0]             own_reg, own_next;
    logic                      last_reg, last_next;
    logic [N_CLIENTS-1:0]      grant_reg, grant_next;
    logic [N_CLIENTS-1:0]      ack_reg, ack_next;
    logic [NOC_BUS_SIZE-1:0]   din_reg, din_next;
    logic                      wr_reg, wr_next;

    logic [N_CLIENTS-1:0]      eligible;
    logic [N_CLIENTS-1:0]      winner;
    logic [PW-1:0]             win_idx;
    logic                      found;
    logic                      own_eligible;
    logic [REQ_W-1:0]          client_flit [N_CLIENTS];

    // A client is masked on its ack cycle so a stale flit is never resent.
    assign eligible     = req_i & ~ack_reg;
    assign own_eligible = eligible[own_reg];

    generate
        for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_slice
            assign client_flit[gi] = flit_i[gi*REQ_W +: REQ_W];
        end
    endgenerate

    rtsnoc_rr_arbiter #(
        .N (N_CLIENTS)
    ) u_rr (
        .eligible (eligible),
        .ptr      (ptr_reg),
        .winner   (winner),
        .win_idx  (win_idx),
        .found    (found)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (found)        state_next = ST_SEND;
            ST_SEND: if (!noc_wait_i)  state_next = last_reg ? ST_IDLE : ST_HOLD;
            ST_HOLD: if (own_eligible) state_next = ST_SEND;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_next   = ptr_reg;
        own_next   = own_reg;
        last_next  = last_reg;
        grant_next = grant_reg;
        din_next   = din_reg;
        ack_next   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (found) begin
                    own_next   = win_idx;
                    grant_next = winner;
                    din_next   = {ORIGIN, client_flit[win_idx]};
                    last_next  = last_i[win_idx];
                end
            end
            ST_SEND: begin
                if (!noc_wait_i) begin
                    ack_next[own_reg] = 1'b1;
                    if (last_reg) begin
                        grant_next = '0;
                        ptr_next   = (own_reg == PW'(N_CLIENTS - 1)) ? '0 : own_reg + PW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (own_eligible) begin
                    din_next  = {ORIGIN, client_flit[own_reg]};
                    last_next = last_i[own_reg];
                end
            end
            default: begin
                grant_next = '0;
            end
        endcase
        wr_next = (state_next == ST_SEND);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg   <= '0;
            own_reg   <= '0;
            last_reg  <= 1'b0;
            grant_reg <= '0;
            ack_reg   <= '0;
            din_reg   <= '0;
            wr_reg    <= 1'b0;
        end else begin
            ptr_reg   <= ptr_next;
            own_reg   <= own_next;
            last_reg  <= last_next;
            grant_reg <= grant_next;
            ack_reg   <= ack_next;
            din_reg   <= din_next;
            wr_reg    <= wr_next;
        end
    end

    assign ack_o     = ack_reg;
    assign grant_o   = grant_reg;
    assign noc_din_o = din_reg;
    assign noc_wr_o  = wr_reg;

endmodule

// File: tb/tb_rtsnoc_tx_arbiter.sv
// Scoreboard bench for rtsnoc_tx_arbiter: client queues drive the DUT, a
// transaction-level round-robin model predicts the transfer sequence.
module tb_rtsnoc_tx_arbiter;

    localparam int N     = 4;
    localparam int REQ_W = 21;
    localparam int BUS   = 26;
    localparam logic       ORIG_X = 1'b1;
    localparam logic       ORIG_Y = 1'b0;
    localparam logic [2:0] ORIG_L = 3'd5;

    typedef struct packed {
        logic        x;
        logic        y;
        logic [2:0]  loc;
        logic [15:0] data;
        logic        last;
    } flit_t;

    typedef struct {
        int             client;
        logic [BUS-1:0] din;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] want;
    } chk_t;

    logic               clk = 1'b0;
    logic               rst_i;
    logic [N-1:0]       req_i;
    logic [N-1:0]       last_i;
    logic [N*REQ_W-1:0] flit_i;
    logic [N-1:0]       ack_o;
    logic [N-1:0]       grant_o;
    logic [BUS-1:0]     noc_din_o;
    logic               noc_wr_o;
    logic               noc_wait_i;

    always #5 clk = ~clk;

    rtsnoc_tx_arbiter #(
        .N_CLIENTS      (N),
        .NOC_LOCAL_ADR  (5),
        .NOC_X          (1),
        .NOC_Y          (0),
        .SOC_SIZE_X     (1),
        .SOC_SIZE_Y     (1),
        .NOC_DATA_WIDTH (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .last_i     (last_i),
        .flit_i     (flit_i),
        .ack_o      (ack_o),
        .grant_o    (grant_o),
        .noc_din_o  (noc_din_o),
        .noc_wr_o   (noc_wr_o),
        .noc_wait_i (noc_wait_i)
    );

    exp_t  sb[$];
    chk_t  chk_q[$];
    flit_t cq[N][$];
    int    ack_cycles[$];
    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;
    int    m_ptr = 0;
    int    wait_pct = 0;
    int    first_wr_cyc = 0;
    int    last_wr_len = 0;
    int    last_ack_cyc = 0;
    int    ack_count = 0;
    logic [BUS-1:0] last_xfer_din = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    logic [N-1:0]   exp_ack = '0;
    logic           prev_wr = 1'b0;
    logic           prev_wait = 1'b0;
    logic [BUS-1:0] prev_din = '0;
    int             wr_run = 0;

    always @(negedge clk) begin
        exp_t e;
        chk_t c;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_vec++;
            if (c.got !== c.want) begin
                n_err++;
                $display("FAIL %s: got %0d, want %0d", c.name, c.got, c.want);
            end
        end
        if (rst_i) begin
            exp_ack   = '0;
            prev_wr   = 1'b0;
            prev_wait = 1'b0;
            wr_run    = 0;
        end else begin
            if (ack_o != '0 || exp_ack != '0) begin
                n_vec++;
                if (ack_o !== exp_ack) begin
                    n_err++;
                    $display("FAIL ack @%0d: got %b, want %b", cyc, ack_o, exp_ack);
                end
                if (ack_o != '0) begin
                    ack_cycles.push_back(cyc);
                    last_ack_cyc = cyc;
                    ack_count++;
                end
            end
            exp_ack = '0;
            if (noc_wr_o) begin
                if (!prev_wr) first_wr_cyc = cyc;
                if (prev_wr && prev_wait) begin
                    n_vec++;
                    if (noc_din_o !== prev_din) begin
                        n_err++;
                        $display("FAIL din_stable @%0d: got %h, want %h", cyc, noc_din_o, prev_din);
                    end
                end
                wr_run++;
                if (!noc_wait_i) begin
                    last_wr_len   = wr_run;
                    wr_run        = 0;
                    last_xfer_din = noc_din_o;
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL xfer @%0d: got unexpected flit %h, want none", cyc, noc_din_o);
                        exp_ack = grant_o;
                    end else begin
                        e = sb.pop_front();
                        exp_ack = N'(1) << e.client;
                        if (grant_o !== exp_ack || noc_din_o !== e.din) begin
                            n_err++;
                            $display("FAIL xfer @%0d: got grant %b din %h, want grant %b din %h",
                                     cyc, grant_o, noc_din_o, exp_ack, e.din);
                        end else begin
                            $display("cycle %0d: client %0d flit %h", cyc, e.client, noc_din_o);
                        end
                    end
                end
            end
            prev_wr   = noc_wr_o;
            prev_wait = noc_wait_i;
            prev_din  = noc_din_o;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        chk_t c;
        c.name = name;
        c.got  = got;
        c.want = want;
        chk_q.push_back(c);
    endtask

    function automatic logic [BUS-1:0] mk_din(input flit_t f);
        return {ORIG_X, ORIG_Y, ORIG_L, f.x, f.y, f.loc, f.data};
    endfunction

    function automatic flit_t rnd_flit(input logic last);
        flit_t f;
        f.x    = 1'($urandom_range(0, 1));
        f.y    = 1'($urandom_range(0, 1));
        f.loc  = 3'($urandom_range(0, 7));
        f.data = 16'($urandom);
        f.last = last;
        return f;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (cq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic add_burst(input int c, input int len);
        for (int k = 0; k < len; k++) cq[c].push_back(rnd_flit(k == len - 1));
    endtask

    // Reference: repeatedly serve the first client at/after the pointer that
    // still has work, emitting its whole burst; the pointer then moves past it.
    task automatic model_run();
        flit_t q[N][$];
        flit_t f;
        int    w;
        for (int i = 0; i < N; i++) q[i] = cq[i];
        forever begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && q[(m_ptr + k) % N].size() > 0) w = (m_ptr + k) % N;
            end
            if (w < 0) break;
            do begin
                exp_t e;
                f = q[w].pop_front();
                e.client = w;
                e.din    = mk_din(f);
                sb.push_back(e);
            end while (!f.last);
            m_ptr = (w + 1) % N;
        end
    endtask

    task automatic tick(input bit w);
        flit_t f;
        @(posedge clk);
        #1;
        noc_wait_i = w;
        for (int i = 0; i < N; i++) begin
            if (ack_o[i]) begin
                if (cq[i].size() > 0) void'(cq[i].pop_front());
                req_i[i] = 1'b0;
            end else if (cq[i].size() > 0) begin
                f = cq[i][0];
                req_i[i]  = 1'b1;
                last_i[i] = f.last;
                flit_i[i*REQ_W +: REQ_W] = {f.x, f.y, f.loc, f.data};
            end else begin
                req_i[i] = 1'b0;
            end
        end
    endtask

    task automatic drain(input string tag);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (sb.size() == 0 && all_empty() && !noc_wr_o) break;
            tick(int'($urandom_range(0, 99)) < wait_pct);
        end
        if (k == 3000) check({tag, "_timeout"}, 32'd1, 32'd0);
        @(negedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        flit_t f;
        int    t0;
        int    n0;
        int    ab;

        rst_i = 1'b1;
        req_i = '0;
        last_i = '0;
        flit_i = '0;
        noc_wait_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("reset_wr",    32'(noc_wr_o),  32'd0);
        check("reset_grant", 32'(grant_o),   32'd0);
        check("reset_ack",   32'(ack_o),     32'd0);
        check("reset_din",   32'(noc_din_o), 32'd0);

        // single flit from client 0, latency and header stamping
        wait_pct = 0;
        f.x = 1'b0; f.y = 1'b1; f.loc = 3'd2; f.data = 16'hBEEF; f.last = 1'b1;
        cq[0].push_back(f);
        model_run();
        tick(1'b0);
        t0 = cyc;
        drain("single");
        check("single_wr_latency",  32'(first_wr_cyc - t0), 32'd1);
        check("single_ack_latency", 32'(last_ack_cyc - t0), 32'd2);
        check("single_din", 32'(last_xfer_din),
              32'({ORIG_X, ORIG_Y, ORIG_L, 1'b0, 1'b1, 3'd2, 16'hBEEF}));

        // same flit stalled by five wait cycles
        cq[0].push_back(f);
        model_run();
        n0 = ack_count;
        tick(1'b0);
        t0 = cyc;
        repeat (5) tick(1'b1);
        drain("wait");
        check("wait_wr_cycles",   32'(last_wr_len),        32'd6);
        check("wait_ack_cycle",   32'(last_ack_cyc - t0),  32'd7);
        check("wait_ack_count",   32'(ack_count - n0),     32'd1);

        // reset while a flit is stuck in SEND
        add_burst(2, 1);
        model_run();
        tick(1'b0);
        tick(1'b1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        noc_wait_i = 1'b1;
        @(negedge clk);
        check("send_before_rst", 32'(noc_wr_o), 32'd1);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        noc_wait_i = 1'b0;
        req_i = '0;
        for (int i = 0; i < N; i++) cq[i].delete();
        sb.delete();
        m_ptr = 0;
        n0 = ack_count;
        @(negedge clk);
        check("rst_wr",    32'(noc_wr_o), 32'd0);
        check("rst_grant", 32'(grant_o),  32'd0);
        tick(1'b0);
        tick(1'b0);
        check("rst_no_ack", 32'(ack_count - n0), 32'd0);

        // all four clients requesting single flits continuously
        for (int c = 0; c < N; c++) begin
            add_burst(c, 1);
            add_burst(c, 1);
        end
        model_run();
        ab = ack_cycles.size();
        drain("rr");
        check("rr_ack_count", 32'(ack_cycles.size() - ab), 32'd8);
        for (int i = ab + 1; i < ack_cycles.size(); i++) begin
            check("rr_ack_gap", 32'(ack_cycles[i] - ack_cycles[i-1]), 32'd2);
        end

        // 3-flit burst from client 1 competing with client 2
        add_burst(1, 3);
        add_burst(2, 1);
        model_run();
        n0 = ack_count;
        drain("burst");
        check("burst_ack_count", 32'(ack_count - n0), 32'd4);

        // randomized batches of bursts with random router back-pressure
        for (int b = 0; b < 25; b++) begin
            wait_pct = int'($urandom_range(0, 60));
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 3) != 0) begin
                    for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                        add_burst(c, int'($urandom_range(1, 4)));
                    end
                end
            end
            model_run();
            drain("rand");
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
